// File: rtl/serial_feeder.sv
// Parallel-to-serial feeder: accepts words of 1..WIDTH bits and streams them
// MSB-first onto x/x_valid, with one holding register for gapless back-to-back words.
module serial_feeder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LW-1:0]    load_len,
  input  logic             pause,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [LW-1:0]    hold_len_q, hold_len_d;
  logic             hold_full_q, hold_full_d;
  logic             done_q, done_d;

  logic [LW-1:0]    eff_len;
  logic [WIDTH-1:0] aligned;
  logic             last_bit;
  logic             accept;

  // Effective length and left-aligned word so the first bit sits at the shifter MSB
  always_comb begin
    eff_len = load_len;
    if ((load_len == '0) || (load_len > WIDTH_L)) begin
      eff_len = WIDTH_L;
    end
    aligned = load_data << (WIDTH_L - eff_len);
  end

  // Handshake: a full holding register frees up on the edge that ends the current word
  always_comb begin
    last_bit   = (state_q == SHIFT) && (cnt_q == ONE_L) && !pause;
    load_ready = !hold_full_q || last_bit;
    accept     = load_valid && load_ready;
  end

  // Next-state logic for the FSM, shifter and holding register
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    hold_data_d = hold_data_q;
    hold_len_d  = hold_len_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!pause) begin
          if (hold_full_q) begin
            // A word parked while paused or at a word end starts now
            shreg_d     = hold_data_q;
            cnt_d       = hold_len_q;
            hold_full_d = 1'b0;
            state_d     = SHIFT;
          end else if (accept) begin
            shreg_d = aligned;
            cnt_d   = eff_len;
            state_d = SHIFT;
          end
        end else if (accept) begin
          // Paused: park the word rather than leaving IDLE
          hold_data_d = aligned;
          hold_len_d  = eff_len;
          hold_full_d = 1'b1;
        end
      end

      SHIFT: begin
        if (!pause) begin
          if (cnt_q == ONE_L) begin
            done_d = 1'b1;
            if (hold_full_q) begin
              shreg_d     = hold_data_q;
              cnt_d       = hold_len_q;
              hold_full_d = 1'b0;
            end else begin
              shreg_d = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - ONE_L;
          end
        end
        // New words always land in the holding register while shifting
        if (accept) begin
          hold_data_d = aligned;
          hold_len_d  = eff_len;
          hold_full_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers, cleared asynchronously so a reset discards words in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      hold_data_q <= '0;
      hold_len_q  <= '0;
      hold_full_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      hold_data_q <= hold_data_d;
      hold_len_q  <= hold_len_d;
      hold_full_q <= hold_full_d;
      done_q      <= done_d;
    end
  end

  // Outputs come straight from registers; pause only masks the valid strobe
  always_comb begin
    x       = shreg_q[WIDTH-1];
    x_valid = (state_q == SHIFT) && !pause;
    busy    = (state_q == SHIFT) || hold_full_q;
    done    = done_q;
  end

endmodule

// File: tb/tb_serial_feeder.sv
// Directed bench for serial_feeder: expected bits are queued on accept and
// popped whenever the DUT presents a valid bit.
module tb_serial_feeder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LW    = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LW-1:0]    load_len;
  logic             pause;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic b;
    logic last;
  } bit_t;

  bit_t sb[$];
  logic done_pending = 1'b0;

  serial_feeder #(.WIDTH(WIDTH), .LW(LW)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .pause      (pause),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: bits of the effective length, MSB first, last one tagged
  function automatic void push_word(input logic [7:0] d, input logic [3:0] len);
    int eff;
    eff = ((len == 4'd0) || (len > 4'd8)) ? 8 : int'(len);
    for (int i = eff - 1; i >= 0; i--) begin
      sb.push_back('{b: d[i], last: (i == 0)});
    end
  endfunction

  // One cycle: check outputs mid-cycle, then take the clock edge
  task automatic cycle();
    bit_t e;
    logic popped_last;
    logic acc;
    popped_last = 1'b0;
    #1;
    chk1("x_valid", x_valid, (sb.size() > 0) && !pause);
    chk1("done", done, done_pending);
    if (x_valid) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk1("x_bit", x, e.b);
        popped_last = e.last;
      end
    end else if (sb.size() > 0) begin
      chk1("x_held", x, sb[0].b);
    end else begin
      chk1("x_idle", x, 1'b0);
    end
    acc = load_valid && load_ready;
    @(posedge clock);
    done_pending = popped_last;
    if (acc) push_word(load_data, load_len);
    #1;
  endtask

  initial begin
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    pause      = 1'b0;

    // Reset values, asynchronously applied
    #1 reset = 1'b0;
    #2;
    chk1("rst_x", x, 1'b0);
    chk1("rst_x_valid", x_valid, 1'b0);
    chk1("rst_load_ready", load_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    #8 reset = 1'b1;
    #1;
    chk1("post_rst_ready", load_ready, 1'b1);
    chk1("post_rst_busy", busy, 1'b0);

    // Single 8-bit word straight from IDLE on the first edge
    load_valid = 1'b1; load_data = 8'b11100111; load_len = 4'd8;
    cycle();
    load_valid = 1'b0;
    chk1("single_busy", busy, 1'b1);
    repeat (10) cycle();
    chkn("single_drain", sb.size(), 0);
    chk1("single_idle_busy", busy, 1'b0);

    // Back-to-back words, second one through the holding register
    load_valid = 1'b1; load_data = 8'b11100111; load_len = 4'd8;
    cycle();
    load_data = 8'h19; load_len = 4'd7;
    chk1("b2b_ready", load_ready, 1'b1);
    cycle();
    load_valid = 1'b0;
    chk1("b2b_busy", busy, 1'b1);
    repeat (17) cycle();
    chkn("b2b_drain", sb.size(), 0);

    // Length 0 means full width; short length takes low bits only
    load_valid = 1'b1; load_data = 8'hA5; load_len = 4'd0;
    cycle();
    load_valid = 1'b0;
    repeat (10) cycle();
    load_valid = 1'b1; load_data = 8'hFD; load_len = 4'd3;
    cycle();
    load_valid = 1'b0;
    repeat (5) cycle();
    chkn("len_drain", sb.size(), 0);

    // Pause mid-word for 3 cycles, loading a word into the holding register meanwhile
    load_valid = 1'b1; load_data = 8'hA5; load_len = 4'd8;
    cycle();
    load_valid = 1'b0;
    repeat (3) cycle();
    pause = 1'b1;
    load_valid = 1'b1; load_data = 8'h0F; load_len = 4'd4;
    chk1("pause_ready", load_ready, 1'b1);
    cycle();
    load_valid = 1'b0;
    chk1("pause_busy", busy, 1'b1);
    repeat (2) cycle();
    pause = 1'b0;
    repeat (12) cycle();
    chkn("pause_drain", sb.size(), 0);

    // Reset during the 4th bit with the holding register full
    load_valid = 1'b1; load_data = 8'b11100111; load_len = 4'd8;
    cycle();
    load_data = 8'h19; load_len = 4'd7;
    cycle();
    load_valid = 1'b0;
    repeat (2) cycle();
    load_valid = 1'b1; load_data = 8'h3C; load_len = 4'd6;
    #1;
    chk1("mid_x_valid", x_valid, 1'b1);
    chk1("mid_x_bit4", x, 1'b0);
    chk1("mid_full_ready", load_ready, 1'b0);
    reset = 1'b0;
    load_valid = 1'b0;
    #1;
    chk1("async_x", x, 1'b0);
    chk1("async_x_valid", x_valid, 1'b0);
    chk1("async_done", done, 1'b0);
    chk1("async_busy", busy, 1'b0);
    chk1("async_ready", load_ready, 1'b1);
    sb.delete();
    done_pending = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (12) cycle();
    chk1("after_rst_busy", busy, 1'b0);

    // A fresh word works normally after the discard
    load_valid = 1'b1; load_data = 8'h81; load_len = 4'd8;
    cycle();
    load_valid = 1'b0;
    repeat (10) cycle();
    chkn("final_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
